debouncer_multi: RTL and testbench
==================================

Name: debouncer_multi

Overview:
Multi-channel, runtime-programmable successor to the single-bit switch debouncer. Each of N_CH asynchronous switch/button inputs is 2FF-synchronised and debounced against a shared runtime threshold. Each channel also produces registered rise/fall strobes, a long-press strobe and sticky event flags. Sits between board-level push-buttons/DIP switches and control logic or a CSR block that polls or clears events.

Parameters:
N_CH, 4, number of independent input channels (>=1)
CNT_W, 16, width of the debounce counter and i_thresh
LONG_W, 24, width of the per-channel long-press counter
LONG_CYC, 1000000, cycles o_sig_debounced must stay 1 before o_long pulses (1..2^LONG_W-1)
RST_LVL, 1'b0, reset value of sync flops and debounced state (all channels)

Ports:
clk  input  1  clock; single clock domain
rst  input  1  asynchronous, active-high reset
i_sig  input  N_CH  raw bouncing inputs, asynchronous to clk
i_thresh  input  CNT_W  debounce threshold in cycles, quasi-static, shared by all channels
i_event_clr  input  N_CH  per-channel clear for o_event (write-1-to-clear style pulse)
o_sig_debounced  output  N_CH  debounced level per channel
o_rise  output  N_CH  1-cycle strobe on debounced 0->1
o_fall  output  N_CH  1-cycle strobe on debounced 1->0
o_long  output  N_CH  1-cycle strobe when debounced level has been 1 for LONG_CYC cycles
o_event  output  N_CH  sticky: set by any rise or fall, held until cleared

Behaviour:
- One clock; reset is asynchronous and active-high. All flops use an asynchronous reset on rst.
- Reset values:
  - Both sync flops and o_sig_debounced = RST_LVL.
  - Debounce counter = 0; long counter = 0; o_rise = o_fall = o_long = o_event = 0.
- Synchroniser: s = i_sig after 2 flops per channel. No combinational path from i_sig to any output.
- Effective threshold T = (i_thresh == 0) ? 1 : i_thresh.
- Debounce counter, per channel, on each edge:
  - if s == db: cnt <= 0.
  - else if cnt >= T-1: db <= s, cnt <= 0.
  - else: cnt <= cnt + 1.
  - Since db is fixed while counting, any s == db sample restarts the count, so glitches shorter than T cycles are rejected.
- Latency: an i_sig transition set up before edge E0 and then held changes o_sig_debounced at edge E0+T+1, i.e. T+2 cycles including sync.
- Counter never wraps. The ">=" compare means lowering i_thresh mid-count causes an update on the next mismatching edge.
- o_rise/o_fall are registered and asserted in the same cycle o_sig_debounced shows its new value, for exactly 1 cycle. Only one of the two can be active per channel per cycle.
- Long press:
  - lcnt clears to 0 on every cycle db == 0.
  - While db == 1, lcnt increments and saturates at LONG_CYC.
  - o_long pulses for 1 cycle in the cycle lcnt reaches LONG_CYC, counting from the first cycle db == 1 (LONG_CYC cycles after o_rise).
  - At most one o_long per press; re-arms only after a fall.
- o_event[i]:
  - set when o_rise[i] | o_fall[i] is 1 (visible the following cycle); cleared when i_event_clr[i] = 1.
  - Simultaneous set and clear: set wins.
- Channels are fully independent; only i_thresh is shared.
- Reset asserted mid-count or mid-press: all state returns to reset values immediately. No strobe is emitted at deassertion if the input equals RST_LVL.
- If RST_LVL=0 and the input is high at reset release, the channel debounces normally and produces o_rise T+2 cycles later; this is expected.

Test Plan:
1. Glitch rejection: T=8, ch0 high for 7 cycles then low -> o_sig_debounced[0] stays 0; no o_rise, o_fall or o_event.
2. Clean press/release: T=8, ch1 held high -> o_sig_debounced[1] and a 1-cycle o_rise[1] exactly 10 cycles after the input edge. Release -> o_fall[1] after 10 cycles; o_event[1] set after each strobe.
3. Long press: LONG_CYC=20, T=4, hold ch2 high 40 cycles -> o_long[2] pulses once, exactly 20 cycles after o_rise[2]. Release and re-press -> pulses again.
4. Channel independence and sticky flags: bounce ch0 and ch3 with different patterns -> strobes only on the correct channels. Assert i_event_clr[3] in the same cycle o_event[3] would be set -> o_event[3] remains 1. A later clear -> 0.
5. Threshold boundaries: i_thresh=0 -> behaves as T=1 (latency 3 cycles). With T=100, counting 50 cycles, drop i_thresh to 10 -> update on the next edge.
6. Async reset mid-operation: assert rst asynchronously during a count and during a long press -> all outputs 0 immediately. Release with inputs low -> no strobes for 100 cycles.

Source files
------------

// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer: per-channel 2FF sync, shared runtime threshold,
// rise/fall/long-press strobes and sticky event flags.
module debouncer_ch #(
  parameter int   CNT_W    = 16,
  parameter int   LONG_W   = 24,
  parameter int   LONG_CYC = 1000000,
  parameter logic RST_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sig,
  input  logic [CNT_W-1:0] i_tm1,
  input  logic             i_event_clr,
  output logic             o_db,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_long,
  output logic             o_event
);
  localparam logic [LONG_W-1:0] LC    = LONG_W'(LONG_CYC);
  localparam logic [LONG_W-1:0] LC_M1 = LONG_W'(LONG_CYC - 1);

  logic              r_s1, r_s2, r_db, r_rise, r_fall, r_long, r_event;
  logic [CNT_W-1:0]  r_cnt;
  logic [LONG_W-1:0] r_lcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= RST_LVL;
      r_s2 <= RST_LVL;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
    end
  end

  // ">=" rather than "==" so a threshold lowered mid-count takes effect at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db   <= RST_LVL;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_tm1) begin
        r_db   <= r_s2;
        r_cnt  <= '0;
        r_rise <= r_s2;
        r_fall <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Saturating at LC gives a single pulse per press; a low level re-arms it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lcnt <= '0;
      r_long <= 1'b0;
    end else if (!r_db) begin
      r_lcnt <= '0;
      r_long <= 1'b0;
    end else if (r_lcnt != LC) begin
      r_lcnt <= r_lcnt + 1'b1;
      r_long <= (r_lcnt == LC_M1);
    end else begin
      r_long <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_event <= 1'b0;
    else if (r_rise | r_fall) r_event <= 1'b1;
    else if (i_event_clr)     r_event <= 1'b0;
  end

  assign o_db    = r_db;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_long  = r_long;
  assign o_event = r_event;
endmodule

module debouncer_multi #(
  parameter int   N_CH     = 4,
  parameter int   CNT_W    = 16,
  parameter int   LONG_W   = 24,
  parameter int   LONG_CYC = 1000000,
  parameter logic RST_LVL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  i_sig,
  input  logic [CNT_W-1:0] i_thresh,
  input  logic [N_CH-1:0]  i_event_clr,
  output logic [N_CH-1:0]  o_sig_debounced,
  output logic [N_CH-1:0]  o_rise,
  output logic [N_CH-1:0]  o_fall,
  output logic [N_CH-1:0]  o_long,
  output logic [N_CH-1:0]  o_event
);
  // Threshold 0 behaves as 1; channels compare against T-1
  logic [CNT_W-1:0] w_tm1;
  assign w_tm1 = (i_thresh == '0) ? '0 : i_thresh - 1'b1;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debouncer_ch #(
      .CNT_W(CNT_W), .LONG_W(LONG_W), .LONG_CYC(LONG_CYC), .RST_LVL(RST_LVL)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_sig      (i_sig[g]),
      .i_tm1      (w_tm1),
      .i_event_clr(i_event_clr[g]),
      .o_db       (o_sig_debounced[g]),
      .o_rise     (o_rise[g]),
      .o_fall     (o_fall[g]),
      .o_long     (o_long[g]),
      .o_event    (o_event[g])
    );
  end
endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: expected strobes are queued by cycle when
// stimulus is driven and compared, with level/event models, every cycle.
module tb_debouncer_multi;
  localparam int N = 4, CW = 16, LW = 24, LC = 20;

  logic          clk = 1'b0, rst = 1'b0;
  logic [N-1:0]  i_sig = '0, i_event_clr = '0;
  logic [CW-1:0] i_thresh = 16'd8;
  logic [N-1:0]  o_sig_debounced, o_rise, o_fall, o_long, o_event;

  int errors = 0, checks = 0, cyc = 0, c0;
  logic [15:0] p0, p3;

  typedef struct { int cyc; int ch; int kind; } exp_t;  // kind: 0 rise, 1 fall, 2 long
  exp_t q[$];
  logic [N-1:0] m_db = '0, m_r = '0, m_f = '0, m_l = '0, m_ev = '0;

  always #5 clk = ~clk;

  debouncer_multi #(.N_CH(N), .CNT_W(CW), .LONG_W(LW), .LONG_CYC(LC), .RST_LVL(1'b0)) dut (
    .clk(clk), .rst(rst), .i_sig(i_sig), .i_thresh(i_thresh), .i_event_clr(i_event_clr),
    .o_sig_debounced(o_sig_debounced), .o_rise(o_rise), .o_fall(o_fall),
    .o_long(o_long), .o_event(o_event)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_ev(int at, int ch, int kind);
    exp_t e;
    e.cyc = at; e.ch = ch; e.kind = kind;
    q.push_back(e);
  endtask

  task automatic model_clear();
    q.delete();
    m_db = '0; m_r = '0; m_f = '0; m_l = '0; m_ev = '0;
  endtask

  task automatic step(int n = 1);
    for (int k = 0; k < n; k++) begin
      logic [N-1:0] clr_s, str_s;
      clr_s = i_event_clr;
      str_s = m_r | m_f;
      @(posedge clk);
      cyc++;
      #1;
      m_r = '0; m_f = '0; m_l = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc) begin
          case (q[i].kind)
            0:       m_r[q[i].ch] = 1'b1;
            1:       m_f[q[i].ch] = 1'b1;
            default: m_l[q[i].ch] = 1'b1;
          endcase
          q.delete(i);
        end
      end
      m_db = (m_db | m_r) & ~m_f;
      m_ev = (m_ev & ~clr_s) | str_s;
      if (rst) model_clear();
      chk($sformatf("cycle %0d {db,rise,fall,long,event}", cyc),
          {12'h0, o_sig_debounced, o_rise, o_fall, o_long, o_event},
          {12'h0, m_db, m_r, m_f, m_l, m_ev});
    end
  endtask

  initial begin
    // reset state
    #1 rst = 1'b1;
    #1;
    chk("reset outputs", {12'h0, o_sig_debounced, o_rise, o_fall, o_long, o_event}, 32'h0);
    step(3);
    rst = 1'b0;

    // glitch of 7 cycles at T=8 must be rejected
    i_thresh = 16'd8;
    i_sig[0] = 1'b1; step(7);
    i_sig[0] = 1'b0; step(20);

    // clean press/release on ch1, long press at LC after rise
    i_sig[1] = 1'b1;
    expect_ev(cyc + 10, 1, 0);
    expect_ev(cyc + 30, 1, 2);
    step(35);
    chk("t2 event after rise", o_event[1], 1);
    i_event_clr[1] = 1'b1; step(1);
    i_event_clr[1] = 1'b0; step(1);
    chk("t2 event cleared", o_event[1], 0);
    i_sig[1] = 1'b0;
    expect_ev(cyc + 10, 1, 1);
    step(15);
    chk("t2 event after fall", o_event[1], 1);

    // long press twice on ch2, T=4
    i_thresh = 16'd4;
    for (int p = 0; p < 2; p++) begin
      i_sig[2] = 1'b1;
      expect_ev(cyc + 6, 2, 0);
      expect_ev(cyc + 26, 2, 2);
      step(40);
      i_sig[2] = 1'b0;
      expect_ev(cyc + 6, 2, 1);
      step(10);
    end

    // independent bounce patterns on ch0/ch3; clear collides with ch3 set
    p0 = 16'hFF3B;
    p3 = 16'hF1DA;
    c0 = cyc;
    expect_ev(c0 + 14, 0, 0);
    expect_ev(c0 + 34, 0, 2);
    expect_ev(c0 + 18, 3, 0);
    expect_ev(c0 + 38, 3, 2);
    for (int i = 0; i < 40; i++) begin
      if (i < 16) begin
        i_sig[0] = p0[i];
        i_sig[3] = p3[i];
      end
      i_event_clr[3] = (cyc == c0 + 18);
      step(1);
    end
    chk("t4 set wins over clear", o_event[3], 1);
    i_event_clr[3] = 1'b1; step(1);
    i_event_clr[3] = 1'b0; step(1);
    chk("t4 later clear", o_event[3], 0);
    i_sig[0] = 1'b0; i_sig[3] = 1'b0;
    expect_ev(cyc + 6, 0, 1);
    expect_ev(cyc + 6, 3, 1);
    step(10);

    // threshold 0 behaves as 1; lowering the threshold mid-count fires next edge
    i_thresh = 16'd0;
    i_sig[1] = 1'b1; expect_ev(cyc + 3, 1, 0); step(10);
    i_sig[1] = 1'b0; expect_ev(cyc + 3, 1, 1); step(10);
    i_thresh = 16'd100;
    i_sig[1] = 1'b1; step(50);
    i_thresh = 16'd10;
    expect_ev(cyc + 1, 1, 0);
    expect_ev(cyc + 21, 1, 2);
    step(25);
    i_sig[1] = 1'b0; expect_ev(cyc + 12, 1, 1); step(15);

    // async reset during a long press (ch2) and a count (ch1)
    i_thresh = 16'd8;
    i_sig[2] = 1'b1; expect_ev(cyc + 10, 2, 0); step(15);
    chk("t6 ch2 high before reset", o_sig_debounced[2], 1);
    i_sig[1] = 1'b1; step(3);
    #2 rst = 1'b1;
    #1;
    chk("t6 async reset outputs", {12'h0, o_sig_debounced, o_rise, o_fall, o_long, o_event}, 32'h0);
    i_sig = '0;
    model_clear();
    step(3);
    rst = 1'b0;
    step(100);
    chk("t6 scoreboard drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
